// File: rtl/hc138_scan_decoder.sv
// hc138_scan_decoder: registered, parametrised successor of the '138 3-to-8
// decoder. Decodes an external address directly, or steps through channels
// 0..NUM_OUT-1 on its own with a fixed dwell time per channel. The '138-style
// enable group freezes the block: outputs go inactive, scan state holds.
module hc138_scan_decoder #(
  parameter int ADDR_W     = 3,
  parameter int NUM_OUT    = 8,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s1,
  input  logic              s2_n,
  input  logic              s3_n,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_OUT-1:0] y_n,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              scan_wrap
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL - 1);
  localparam logic [ADDR_W-1:0]  LAST_CH    = ADDR_W'(NUM_OUT - 1);
  localparam logic [ADDR_W:0]    NUM_CH     = (ADDR_W + 1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] INACTIVE   = (ACTIVE_LOW != 0) ? {NUM_OUT{1'b1}}
                                                                : {NUM_OUT{1'b0}};

  // One-hot decode in output polarity; an out-of-range channel selects nothing,
  // which keeps y_n at most one-hot for any address.
  function automatic logic [NUM_OUT-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_OUT-1:0] v;
    v = {NUM_OUT{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      if ({1'b0, a} == (ADDR_W + 1)'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  logic                gate;
  logic                mode_q;
  logic [DW-1:0]       dwell;
  logic [ADDR_W-1:0]   entry_ch;
  logic [ADDR_W-1:0]   cur_next;
  logic [DW-1:0]       dwell_next;
  logic                mode_next;
  logic [NUM_OUT-1:0]  y_next;
  logic                wrap_next;

  assign gate = en & s1 & ~s2_n & ~s3_n;

  // Scan entry channel: the supplied address when in range, otherwise channel 0.
  always_comb begin
    if ({1'b0, addr} < NUM_CH) begin
      entry_ch = addr;
    end else begin
      entry_ch = {ADDR_W{1'b0}};
    end
  end

  // Next-state for channel, dwell count, registered mode and the outputs.
  always_comb begin
    cur_next   = cur_addr;
    dwell_next = dwell;
    mode_next  = mode_q;
    y_next     = INACTIVE;
    wrap_next  = 1'b0;
    if (gate) begin
      mode_next = mode;
      if (!mode) begin
        // Direct decode; an out-of-range address is still tracked in cur_addr.
        cur_next   = addr;
        dwell_next = {DW{1'b0}};
        y_next     = decode(addr);
      end else if (!mode_q) begin
        // First scan cycle: start from the supplied channel.
        cur_next   = entry_ch;
        dwell_next = {DW{1'b0}};
        y_next     = decode(entry_ch);
      end else if (dwell < DWELL_LAST) begin
        // Stay on the channel; re-decode so a resumed scan lights it again.
        dwell_next = dwell + DW'(1);
        y_next     = decode(cur_addr);
      end else begin
        dwell_next = {DW{1'b0}};
        if (cur_addr == LAST_CH) begin
          cur_next  = {ADDR_W{1'b0}};
          wrap_next = 1'b1;
        end else begin
          cur_next  = cur_addr + ADDR_W'(1);
          wrap_next = 1'b0;
        end
        y_next = decode(cur_next);
      end
    end else begin
      // Disabled: outputs inactive, scan state frozen (defaults above).
      mode_next = mode_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr  <= {ADDR_W{1'b0}};
      dwell     <= {DW{1'b0}};
      mode_q    <= 1'b0;
      scan_wrap <= 1'b0;
      y_n       <= INACTIVE;
    end else begin
      cur_addr  <= cur_next;
      dwell     <= dwell_next;
      mode_q    <= mode_next;
      scan_wrap <= wrap_next;
      y_n       <= y_next;
    end
  end

endmodule
